// File: rtl/pipe_stage_buf_if.sv
// Valid/ready handshake bus carrying one DW-bit pipeline payload.
interface pipe_stage_buf_if #(
    parameter int unsigned DW = 114
);
    logic          valid;
    logic          ready;
    logic [DW-1:0] data;

    // Producer side drives valid/data, consumer side drives ready.
    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_stage_buf.sv
// Parametrised pipeline stage register: valid/ready handshake, optional
// 2-entry skid buffer (registered ready), flush, stall/bubble counters.
module pipe_stage_buf #(
    parameter int unsigned DW    = 114,
    parameter int unsigned SKID  = 1,
    parameter int unsigned CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush_i,
    pipe_stage_buf_if.slave    in_if,
    pipe_stage_buf_if.master   out_if,
    output logic [CNT_W-1:0]   stall_cnt_o,
    output logic [CNT_W-1:0]   bubble_cnt_o
);

    // ST_ONE doubles as FULL when the skid entry is disabled.
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [DW-1:0]    main_q, main_d;
    logic [DW-1:0]    skid_q, skid_d;
    logic             out_valid_q, out_valid_d;
    logic [CNT_W-1:0] stall_cnt_q, bubble_cnt_q;

    logic             in_ready;
    logic             xfer_in;
    logic             xfer_out;

    assign xfer_in  = in_if.valid & in_ready;
    assign xfer_out = out_valid_q & out_if.ready;

    // Ready generation: registered from next state with skid, else pass-through.
    if (SKID != 0) begin : g_skid
        logic in_ready_q;

        // Ready is dropped only while both entries are occupied.
        always_ff @(posedge clk) begin
            if (rst) begin
                in_ready_q <= 1'b1;
            end else begin
                in_ready_q <= (state_d != ST_TWO);
            end
        end

        assign in_ready = in_ready_q;
    end else begin : g_noskid
        assign in_ready = ~out_valid_q | out_if.ready;
    end

    // Next-state and payload movement; flush wins over any incoming transfer.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush_i) begin
            state_d = ST_EMPTY;
            main_d  = '0;
            skid_d  = '0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (xfer_in) begin
                        state_d = ST_ONE;
                        main_d  = in_if.data;
                    end
                end
                ST_ONE: begin
                    if (xfer_in && xfer_out) begin
                        main_d = in_if.data;
                    end else if (xfer_in && (SKID != 0)) begin
                        state_d = ST_TWO;
                        skid_d  = in_if.data;
                    end else if (xfer_out) begin
                        state_d = ST_EMPTY;
                        main_d  = '0;
                    end
                end
                ST_TWO: begin
                    if (xfer_out) begin
                        state_d = ST_ONE;
                        main_d  = skid_q;
                        skid_d  = '0;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                    main_d  = '0;
                    skid_d  = '0;
                end
            endcase
        end
        out_valid_d = (state_d != ST_EMPTY);
    end

    // State and payload registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Saturating stall/bubble counters, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            if (out_valid_q && !out_if.ready && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (!out_valid_q && out_if.ready && (bubble_cnt_q != '1)) begin
                bubble_cnt_q <= bubble_cnt_q + CNT_W'(1);
            end
        end
    end

    assign in_if.ready  = in_ready;
    assign out_if.valid = out_valid_q;
    assign out_if.data  = main_q;
    assign stall_cnt_o  = stall_cnt_q;
    assign bubble_cnt_o = bubble_cnt_q;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: SKID=1 and SKID=0 instances side by side.
module tb_pipe_stage_buf;

    localparam int unsigned DW    = 114;
    localparam int unsigned CNT_W = 16;

    logic clk = 1'b0;
    logic rst;
    logic flush1, flush0;
    logic [CNT_W-1:0] stall1, bubble1, stall0, bubble0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_stage_buf_if #(.DW(DW)) in1 ();
    pipe_stage_buf_if #(.DW(DW)) out1 ();
    pipe_stage_buf_if #(.DW(DW)) in0 ();
    pipe_stage_buf_if #(.DW(DW)) out0 ();

    pipe_stage_buf #(.DW(DW), .SKID(1), .CNT_W(CNT_W)) dut1 (
        .clk(clk), .rst(rst), .flush_i(flush1),
        .in_if(in1.slave), .out_if(out1.master),
        .stall_cnt_o(stall1), .bubble_cnt_o(bubble1)
    );

    pipe_stage_buf #(.DW(DW), .SKID(0), .CNT_W(CNT_W)) dut0 (
        .clk(clk), .rst(rst), .flush_i(flush0),
        .in_if(in0.slave), .out_if(out0.master),
        .stall_cnt_o(stall0), .bubble_cnt_o(bubble0)
    );

    typedef struct {
        logic          iv;
        logic [DW-1:0] id;
        logic          ordy;
        logic          fl;
        logic          ev;
        logic [DW-1:0] ed;
        logic          er;
    } vec_t;

    vec_t tbl[$];
    logic [DW-1:0] q1[$];
    logic [DW-1:0] q0[$];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_st1, exp_bb1, exp_st0, exp_bb0;
        rst = 1'b1;
        flush1 = 1'b0; flush0 = 1'b0;
        in1.valid = 1'b0; in1.data = '0; out1.ready = 1'b0;
        in0.valid = 1'b0; in0.data = '0; out0.ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        chk("rst s1 valid", DW'(out1.valid), DW'(0));
        chk("rst s1 data", out1.data, DW'(0));
        chk("rst s1 ready", DW'(in1.ready), DW'(1));
        chk("rst s1 stall", DW'(stall1), DW'(0));
        chk("rst s1 bubble", DW'(bubble1), DW'(0));
        chk("rst s0 valid", DW'(out0.valid), DW'(0));
        chk("rst s0 ready", DW'(in0.ready), DW'(1));

        // Table: stream, skid fill/drain, flush in TWO and in EMPTY
        tbl.push_back('{1'b1, DW'(1), 1'b0, 1'b0, 1'b1, DW'(1), 1'b1});
        for (int k = 2; k <= 8; k++)
            tbl.push_back('{1'b1, DW'(k), 1'b1, 1'b0, 1'b1, DW'(k), 1'b1});
        tbl.push_back('{1'b0, DW'(0),    1'b1, 1'b0, 1'b0, DW'(0),    1'b1});
        tbl.push_back('{1'b1, DW'('hA),  1'b0, 1'b0, 1'b1, DW'('hA),  1'b1});
        tbl.push_back('{1'b1, DW'('hB),  1'b0, 1'b0, 1'b1, DW'('hA),  1'b0});
        tbl.push_back('{1'b1, DW'('hEE), 1'b0, 1'b0, 1'b1, DW'('hA),  1'b0});
        tbl.push_back('{1'b0, DW'(0),    1'b1, 1'b0, 1'b1, DW'('hB),  1'b1});
        tbl.push_back('{1'b0, DW'(0),    1'b1, 1'b0, 1'b0, DW'(0),    1'b1});
        tbl.push_back('{1'b1, DW'('hA),  1'b0, 1'b0, 1'b1, DW'('hA),  1'b1});
        tbl.push_back('{1'b1, DW'('hB),  1'b0, 1'b0, 1'b1, DW'('hA),  1'b0});
        tbl.push_back('{1'b1, DW'('hC),  1'b0, 1'b1, 1'b0, DW'(0),    1'b1});
        tbl.push_back('{1'b0, DW'(0),    1'b0, 1'b0, 1'b0, DW'(0),    1'b1});
        tbl.push_back('{1'b1, DW'('hD),  1'b0, 1'b1, 1'b0, DW'(0),    1'b1});
        tbl.push_back('{1'b0, DW'(0),    1'b0, 1'b0, 1'b0, DW'(0),    1'b1});

        foreach (tbl[i]) begin
            in1.valid  = tbl[i].iv;
            in1.data   = tbl[i].id;
            out1.ready = tbl[i].ordy;
            flush1     = tbl[i].fl;
            tick();
            chk($sformatf("vec%0d valid", i), DW'(out1.valid), DW'(tbl[i].ev));
            chk($sformatf("vec%0d data", i), out1.data, tbl[i].ed);
            chk($sformatf("vec%0d ready", i), DW'(in1.ready), DW'(tbl[i].er));
        end
        in1.valid = 1'b0; out1.ready = 1'b0; flush1 = 1'b0;
        chk("tbl s1 stall", DW'(stall1), DW'(4));
        chk("tbl s1 bubble", DW'(bubble1), DW'(0));

        // SKID=0: replace-on-full with combinational ready, hold, flush
        in0.valid = 1'b1; in0.data = DW'(5); out0.ready = 1'b0;
        #1 chk("s0 empty ready", DW'(in0.ready), DW'(1));
        tick();
        chk("s0 full valid", DW'(out0.valid), DW'(1));
        chk("s0 full data", out0.data, DW'(5));
        chk("s0 full ready", DW'(in0.ready), DW'(0));
        in0.data = DW'(6); out0.ready = 1'b1;
        #1 chk("s0 comb ready", DW'(in0.ready), DW'(1));
        tick();
        chk("s0 replace data", out0.data, DW'(6));
        chk("s0 replace valid", DW'(out0.valid), DW'(1));
        in0.valid = 1'b0; out0.ready = 1'b0;
        #1 chk("s0 stalled ready", DW'(in0.ready), DW'(0));
        tick();
        chk("s0 hold data", out0.data, DW'(6));
        flush0 = 1'b1; in0.valid = 1'b1; in0.data = DW'(7);
        tick();
        flush0 = 1'b0; in0.valid = 1'b0;
        chk("s0 flush valid", DW'(out0.valid), DW'(0));
        chk("s0 flush data", out0.data, DW'(0));
        chk("s0 flush ready", DW'(in0.ready), DW'(1));
        tick();
        chk("s0 post flush valid", DW'(out0.valid), DW'(0));
        chk("s0 stall", DW'(stall0), DW'(2));
        chk("s0 bubble", DW'(bubble0), DW'(0));

        // Reset while TWO is occupied
        in1.valid = 1'b1; in1.data = DW'('h11); tick();
        in1.data = DW'('h22); tick();
        chk("two ready", DW'(in1.ready), DW'(0));
        rst = 1'b1; in1.data = DW'('h33);
        tick();
        rst = 1'b0; in1.valid = 1'b0;
        chk("rst two valid", DW'(out1.valid), DW'(0));
        chk("rst two data", out1.data, DW'(0));
        chk("rst two ready", DW'(in1.ready), DW'(1));
        chk("rst two stall", DW'(stall1), DW'(0));
        tick();
        chk("rst two after valid", DW'(out1.valid), DW'(0));

        // Stall counter saturation and clear by reset
        in1.valid = 1'b1; in1.data = DW'(1); out1.ready = 1'b0;
        tick();
        in1.valid = 1'b0;
        repeat (66000) tick();
        chk("sat stall", DW'(stall1), DW'(16'hFFFF));
        chk("sat held data", out1.data, DW'(1));
        tick();
        chk("sat stall held", DW'(stall1), DW'(16'hFFFF));
        chk("sat bubble", DW'(bubble1), DW'(0));
        flush1 = 1'b1; tick(); flush1 = 1'b0;
        chk("sat flush keeps stall", DW'(stall1), DW'(16'hFFFF));
        rst = 1'b1; tick(); rst = 1'b0;
        chk("sat rst stall", DW'(stall1), DW'(0));

        // Random valid/ready/flush scoreboard on both instances
        exp_st1 = 0; exp_bb1 = 0; exp_st0 = 0; exp_bb0 = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic [127:0] r1, r0;
            logic er1, er0;
            r1 = {$urandom, $urandom, $urandom, $urandom};
            r0 = {$urandom, $urandom, $urandom, $urandom};
            in1.valid  = 1'($urandom_range(0, 1));
            in1.data   = r1[DW-1:0];
            out1.ready = 1'($urandom_range(0, 1));
            flush1     = ($urandom_range(0, 31) == 0);
            in0.valid  = 1'($urandom_range(0, 1));
            in0.data   = r0[DW-1:0];
            out0.ready = 1'($urandom_range(0, 1));
            flush0     = ($urandom_range(0, 31) == 0);
            #1;
            er1 = (q1.size() < 2);
            er0 = (q0.size() == 0) || out0.ready;
            chk("rnd s1 ready", DW'(in1.ready), DW'(er1));
            chk("rnd s1 valid", DW'(out1.valid), DW'(q1.size() != 0));
            chk("rnd s1 data", out1.data, (q1.size() != 0) ? q1[0] : DW'(0));
            chk("rnd s0 ready", DW'(in0.ready), DW'(er0));
            chk("rnd s0 valid", DW'(out0.valid), DW'(q0.size() != 0));
            chk("rnd s0 data", out0.data, (q0.size() != 0) ? q0[0] : DW'(0));
            if (q1.size() != 0 && !out1.ready) exp_st1++;
            if (q1.size() == 0 && out1.ready) exp_bb1++;
            if (q0.size() != 0 && !out0.ready) exp_st0++;
            if (q0.size() == 0 && out0.ready) exp_bb0++;
            if (q1.size() != 0 && out1.ready) void'(q1.pop_front());
            if (q0.size() != 0 && out0.ready) void'(q0.pop_front());
            if (flush1) q1.delete();
            else if (in1.valid && er1) q1.push_back(in1.data);
            if (flush0) q0.delete();
            else if (in0.valid && er0) q0.push_back(in0.data);
            tick();
        end
        flush1 = 1'b0; flush0 = 1'b0; in1.valid = 1'b0; in0.valid = 1'b0;
        chk("rnd s1 stall", DW'(stall1), DW'(exp_st1));
        chk("rnd s1 bubble", DW'(bubble1), DW'(exp_bb1));
        chk("rnd s0 stall", DW'(stall0), DW'(exp_st0));
        chk("rnd s0 bubble", DW'(bubble0), DW'(exp_bb0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
